// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: controller states,
// register-number type and the bundle of per-stage enables/flushes.
package hazard_ctrl_pkg;

  typedef logic [4:0] regbits;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALTED
  } hzd_state_t;

  // One decision for the whole pipeline in a cycle.
  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidFlush;
    logic idexFlush;
  } pipeCtrl_t;

  localparam pipeCtrl_t CTRL_FREEZE   = pipeCtrl_t'(7'b00000_00);
  localparam pipeCtrl_t CTRL_ADVANCE  = pipeCtrl_t'(7'b11111_00);
  localparam pipeCtrl_t CTRL_REDIRECT = pipeCtrl_t'(7'b11111_11);
  localparam pipeCtrl_t CTRL_LOADUSE  = pipeCtrl_t'(7'b00111_01);
  localparam pipeCtrl_t CTRL_IMISS    = pipeCtrl_t'(7'b01111_10);

  // A load into r0 never produces a value worth waiting for.
  function automatic logic isLoadUse(logic memToReg, regbits wrDest,
                                     regbits rs, regbits rt);
    return memToReg && (wrDest != '0) && ((wrDest == rs) || (wrDest == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard inputs from ID/EX/MEM/WB and the sequencing outputs.
// hzd is the controller's view, tb drives the inputs and observes the rest.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  regbits             id_rs;
  regbits             id_rt;
  logic               ex_MemtoReg;
  regbits             ex_WrDest;
  logic               ex_redirect;
  logic               mem_dREN;
  logic               mem_dWEN;
  logic               dhit;
  logic               ihit;
  logic               wb_halt;

  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               exmem_en;
  logic               memwb_en;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic               halt;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   stall_cnt;

  modport hzd (
    input  id_rs, id_rt, ex_MemtoReg, ex_WrDest, ex_redirect,
           mem_dREN, mem_dWEN, dhit, ihit, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, cyc_cnt, stall_cnt
  );

  modport tb (
    output id_rs, id_rt, ex_MemtoReg, ex_WrDest, ex_redirect,
           mem_dREN, mem_dWEN, dhit, ihit, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, cyc_cnt, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: combinational stage enables/flushes from
// cache handshakes, load-use, redirects and halt, plus cycle/stall counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            CLK,
  input  logic            RST,
  hazard_ctrl_if.hzd      bus
);

  hzd_state_t        state;
  hzd_state_t        nextState;
  pipeCtrl_t         ctl;
  logic              dPend;
  logic              loadUse;
  logic [CNT_W-1:0]  cycCnt;
  logic [CNT_W-1:0]  stallCnt;
  logic              haltReg;

  assign dPend   = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
  assign loadUse = isLoadUse(bus.ex_MemtoReg, bus.ex_WrDest, bus.id_rs, bus.id_rt);

  // DWAIT shares the RUN decision table: while the miss is outstanding dPend
  // holds the freeze, and the dhit cycle falls through to the lower rules.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    ctl       = CTRL_FREEZE;
    nextState = state;
    if (state == HALTED) begin
      ctl       = CTRL_FREEZE;
    end else if (bus.wb_halt) begin
      ctl       = CTRL_FREEZE;
      nextState = HALTED;
    end else if (dPend) begin
      ctl       = CTRL_FREEZE;
      nextState = DWAIT;
    end else begin
      nextState = RUN;
      if (bus.ex_redirect)  ctl = CTRL_REDIRECT;
      else if (loadUse)     ctl = CTRL_LOADUSE;
      else if (!bus.ihit)   ctl = CTRL_IMISS;
      else                  ctl = CTRL_ADVANCE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      haltReg  <= 1'b0;
      cycCnt   <= '0;
      stallCnt <= '0;
    end else begin
      state <= nextState;
      if (nextState == HALTED) haltReg <= 1'b1;
      if (state != HALTED) begin
        cycCnt <= cycCnt + 1'b1;
        if (!ctl.pcEn) stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  assign bus.pc_en       = ctl.pcEn;
  assign bus.ifid_en     = ctl.ifidEn;
  assign bus.idex_en     = ctl.idexEn;
  assign bus.exmem_en    = ctl.exmemEn;
  assign bus.memwb_en    = ctl.memwbEn;
  assign bus.ifid_flush  = ctl.ifidFlush;
  assign bus.idex_flush  = ctl.idexFlush;
  assign bus.exmem_flush = 1'b0;
  assign bus.halt        = haltReg;
  assign bus.cyc_cnt     = cycCnt;
  assign bus.stall_cnt   = stallCnt;

endmodule
